// File: rtl/word_display_if.sv
// rtl/word_display_if.sv - word select in, segment/anode/dp drive out for the display scanner.
interface word_display_if;
  logic [1:0] Wordsel;
  logic [6:0] seg;
  logic [3:0] an;
  logic       dp;

  modport master (output Wordsel, input seg, input an, input dp);
  modport slave  (input Wordsel, output seg, output an, output dp);
endinterface

// File: rtl/word_display.sv
// rtl/word_display.sv - 4-digit multiplexed 7-segment word display (PLAY/DEAD/GO/blank).
// Optional DEAD blinking is compiled in by defining WORD_DISPLAY_BLINK_EN.
module word_display #(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLINK_FRAMES = 125
) (
  input  logic          clk,
  input  logic          reset,
  word_display_if.slave bus
);
  localparam int PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

  // Active-low glyphs, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] G_P     = 7'h0C;
  localparam logic [6:0] G_L     = 7'h47;
  localparam logic [6:0] G_A     = 7'h08;
  localparam logic [6:0] G_Y     = 7'h11;
  localparam logic [6:0] G_D     = 7'h21;
  localparam logic [6:0] G_E     = 7'h06;
  localparam logic [6:0] G_G     = 7'h42;
  localparam logic [6:0] G_O     = 7'h40;
  localparam logic [6:0] G_BLANK = 7'h7F;

  if (REFRESH_DIV < 2 || BLINK_FRAMES < 1) begin : g_param_check
    $error("word_display: REFRESH_DIV must be >= 2 and BLINK_FRAMES >= 1");
  end

  logic [PW-1:0] r_presc;
  logic [1:0]    r_idx;
  logic [1:0]    r_word;
  logic [6:0]    r_seg;
  logic [3:0]    r_an;

  logic          w_tick;
  logic          w_frame;
  logic [1:0]    w_idx_next;
  logic [1:0]    w_word_next;
  logic          w_dark;

  function automatic logic [6:0] glyph(input logic [1:0] word, input logic [1:0] idx);
    logic [6:0] g;
    g = G_BLANK;
    case ({word, idx})
      4'b00_00: g = G_P;
      4'b00_01: g = G_L;
      4'b00_10: g = G_A;
      4'b00_11: g = G_Y;
      4'b01_00: g = G_D;
      4'b01_01: g = G_E;
      4'b01_10: g = G_A;
      4'b01_11: g = G_D;
      4'b10_00: g = G_G;
      4'b10_01: g = G_O;
      default:  g = G_BLANK;
    endcase
    return g;
  endfunction

  assign w_tick      = (r_presc == PW'(REFRESH_DIV - 1));
  assign w_frame     = w_tick && (r_idx == 2'd3);
  assign w_idx_next  = r_idx + 2'd1;
  // Outputs at a frame boundary must reflect the word sampled on that same edge
  assign w_word_next = w_frame ? bus.Wordsel : r_word;

`ifdef WORD_DISPLAY_BLINK_EN
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [FW-1:0] r_fcnt;
  logic          r_phase_on;
  logic [FW-1:0] w_fcnt_next;
  logic          w_phase_next;

  always_comb begin
    w_fcnt_next  = r_fcnt;
    w_phase_next = r_phase_on;
    if (w_frame) begin
      if (bus.Wordsel == 2'b01 && r_word != 2'b01) begin
        w_fcnt_next  = '0;
        w_phase_next = 1'b1;
      end else if (r_fcnt == FW'(BLINK_FRAMES - 1)) begin
        w_fcnt_next  = '0;
        w_phase_next = ~r_phase_on;
      end else begin
        w_fcnt_next = r_fcnt + FW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fcnt     <= '0;
      r_phase_on <= 1'b1;
    end else begin
      r_fcnt     <= w_fcnt_next;
      r_phase_on <= w_phase_next;
    end
  end

  assign w_dark = (w_word_next == 2'b11) || (w_word_next == 2'b01 && !w_phase_next);
`else
  assign w_dark = (w_word_next == 2'b11);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_presc <= '0;
      r_idx   <= 2'd3;
      r_word  <= 2'b11;
      r_seg   <= G_BLANK;
      r_an    <= 4'b1111;
    end else begin
      r_presc <= w_tick ? '0 : r_presc + PW'(1);
      if (w_tick) begin
        r_idx  <= w_idx_next;
        r_word <= w_word_next;
        if (w_dark) begin
          r_seg <= G_BLANK;
          r_an  <= 4'b1111;
        end else begin
          r_seg <= glyph(w_word_next, w_idx_next);
          r_an  <= ~(4'b1000 >> w_idx_next);
        end
      end
    end
  end

  assign bus.seg = r_seg;
  assign bus.an  = r_an;
  assign bus.dp  = 1'b1;
endmodule

// File: doc/word_display.md
WORD_DISPLAY -- requirements
Module: word_display

Interface
REQ-001 Parameter REFRESH_DIV, default 100000, clk cycles per digit slot (1 kHz digit rate at 100 MHz); SHALL be >= 2.
REQ-002 Parameter BLINK_FRAMES, default 125, frames per blink half-period (0.5 s at default refresh).
REQ-003 clk  input  1  system clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 Wordsel  input  2  word code from game FSM: 00 PLAY, 01 DEAD, 10 GO, 11 blank.
REQ-006 seg  output  7  cathodes {g,f,e,d,c,b,a}, active-low.
REQ-007 an  output  4  digit anodes, active-low; an[3] is the leftmost digit.
REQ-008 dp  output  1  decimal point, active-low; held 1 (off) at all times.

Function
REQ-009 Prescaler counts 0..REFRESH_DIV-1 and wraps; a tick is the cycle in which it equals REFRESH_DIV-1.
REQ-010 Digit index (2 bits) SHALL advance by 1 mod 4 on each tick only.
REQ-011 Frame boundary = tick where index goes 3->0; on that edge Wordsel SHALL be sampled into the latched word.
REQ-012 Wordsel changes between frame boundaries SHALL NOT affect the display; a value present only mid-frame is never shown.
REQ-013 Index 0..3 SHALL drive an[3]..an[0] respectively, exactly one anode low, showing characters left to right.
REQ-014 seg/an SHALL be registered, loaded on the tick edge from the new index and the latched word (word sampled on that same edge at a frame boundary); no combinational path from Wordsel to outputs.
REQ-015 Words: PLAY = P,L,A,Y; DEAD = d,E,A,d; GO = G,O,blank,blank; 11 = four blanks with an=1111.
REQ-016 Glyph lit segments: P=a,b,e,f,g; L=d,e,f; A=a,b,c,e,f,g; Y=b,c,d,f,g; d=b,c,d,e,g; E=a,d,e,f,g; G=a,c,d,e,f; O=a,b,c,d,e,f; blank=none (seg=7'h7F).
REQ-017 Blank character slot SHALL drive seg=7'h7F with its anode still low (scan timing unchanged).

Reset
REQ-018 While reset is high on an edge: prescaler=0, index=3, latched word=11, seg=7'h7F, an=4'b1111, dp=1.
REQ-019 First tick after reset SHALL be a frame boundary (index 3->0), latching Wordsel and driving an=4'b0111.
REQ-020 Reset asserted mid-frame SHALL blank outputs on the next edge regardless of prescaler/index.

Configuration
REQ-021 Macro WORD_DISPLAY_BLINK_EN, when defined, compiles in DEAD blinking; when undefined, no blink logic exists and DEAD is steady.
REQ-022 With macro: frame counter counts frame boundaries; every BLINK_FRAMES frames a blink phase toggles.
REQ-023 With macro: while latched word=01 and phase=off, an=4'b1111 and seg=7'h7F; other words never blink.
REQ-024 With macro: a frame boundary latching 01 from a different word SHALL reset frame counter to 0 and phase to on.
REQ-025 With macro: reset clears frame counter to 0 and phase to on.

Verification (REFRESH_DIV=4, BLINK_FRAMES=2)
REQ-026 Reset 3 cycles, Wordsel=00 -> an=1111 until first tick (cycle 4), then an 0111/1011/1101/1110 showing P,L,A,Y every 4 cycles.
REQ-027 Wordsel 00->01 mid-frame (index 1) -> remaining digits still L,A,Y; next frame d,E,A,d.
REQ-028 Wordsel=01 pulsed for 3 cycles inside one frame -> display never shows DEAD glyphs.
REQ-029 Wordsel=10 -> G,O then two slots seg=7'h7F with an[1], an[0] low in turn; Wordsel=11 -> an=1111 whole frame.
REQ-030 Reset asserted at index 2 -> next edge seg=7'h7F, an=1111; dp=1 throughout all scenarios.
REQ-031 WORD_DISPLAY_BLINK_EN defined, Wordsel=01 -> frames visible 2, blank 2, visible 2; undefined -> every frame visible.
